// File: rtl/hex_display_scanner_pkg.sv
// hex_display_scanner_pkg: glyph codes, segment constants and slot encoding shared by display drivers
package hex_display_scanner_pkg;
  localparam logic [4:0] GLYPH_DASH = 5'h10;
  localparam logic [4:0] GLYPH_UNDERSCORE = 5'h11;
  localparam logic [4:0] GLYPH_BLANK = 5'h12;
  localparam logic [4:0] GLYPH_TOP = 5'h13;
  localparam logic [4:0] GLYPH_LOW_O = 5'h14;
  localparam logic [4:0] GLYPH_HIGH_O = 5'h15;
  localparam logic [4:0] GLYPH_LEFT_ONE = 5'h16;
  localparam logic [4:0] GLYPH_DOUBLE_EL = 5'h17;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  typedef enum logic [1:0] {S0, S1, S2} slot_t;
endpackage

// File: rtl/hex_display_scanner_glyph_to_segments.sv
// glyph_to_segments: combinational 5-bit glyph code to active-low {dp,g,f,e,d,c,b,a} decoder
module glyph_to_segments
  import hex_display_scanner_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (code)
      5'h00: seg = 8'hC0;
      5'h01: seg = 8'hF9;
      5'h02: seg = 8'hA4;
      5'h03: seg = 8'hB0;
      5'h04: seg = 8'h99;
      5'h05: seg = 8'h92;
      5'h06: seg = 8'h82;
      5'h07: seg = 8'hF8;
      5'h08: seg = 8'h80;
      5'h09: seg = 8'h90;
      5'h0A: seg = 8'h88;
      5'h0B: seg = 8'h83;
      5'h0C: seg = 8'hC6;
      5'h0D: seg = 8'hA1;
      5'h0E: seg = 8'h86;
      5'h0F: seg = 8'h8E;
      GLYPH_DASH: seg = 8'hBF;
      GLYPH_UNDERSCORE: seg = 8'hF7;
      GLYPH_BLANK: seg = SEG_OFF;
      GLYPH_TOP: seg = 8'hFE;
      GLYPH_LOW_O: seg = 8'hA3;
      GLYPH_HIGH_O: seg = 8'h9C;
      GLYPH_LEFT_ONE: seg = 8'hCF;
      GLYPH_DOUBLE_EL: seg = 8'hC9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: 3-digit common-anode multiplexer with per-slot blanking and frame tick
// Optional LEADING_ZERO_BLANK_EN suppresses leading zeros on the two left digits.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 4000,
  parameter int BLANK_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] hex2,
  input  logic [4:0] hex1,
  input  logic [4:0] hex0,
  output logic [7:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);
  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  slot_t slot;
  logic [TW-1:0] tick;
  logic [4:0] l2, l1, l0, c2, c1, c0, e2, e1, code;
  logic first, last;
  logic [7:0] dec;
  assign first = slot == S0 && tick == '0;
  assign last = tick == TW'(TICKS_PER_DIGIT - 1);
  // The first cycle of a frame decodes the codes being latched, so a frame never mixes old and new
  always_comb begin
    c2 = first ? hex2 : l2;
    c1 = first ? hex1 : l1;
    c0 = first ? hex0 : l0;
`ifdef LEADING_ZERO_BLANK_EN
    e2 = c2 == 5'h00 ? GLYPH_BLANK : c2;
    e1 = (c2 == 5'h00 && c1 == 5'h00) ? GLYPH_BLANK : c1;
`else
    e2 = c2;
    e1 = c1;
`endif
    code = slot == S2 ? e2 : slot == S1 ? e1 : c0;
  end
  glyph_to_segments u_dec (.code(code), .seg(dec));
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
      slot <= S0;
      {l2, l1, l0} <= {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK};
      seg <= SEG_OFF;
      an <= 3'b111;
      frame_tick <= 1'b0;
    end else begin
      tick <= last ? '0 : tick + 1'b1;
      if (last) slot <= slot == S0 ? S1 : slot == S1 ? S2 : S0;
      if (first) {l2, l1, l0} <= {hex2, hex1, hex0};
      frame_tick <= first;
      seg <= dec;
      an <= (int'(tick) < BLANK_TICKS || !enable) ? 3'b111 :
            slot == S0 ? 3'b110 : slot == S1 ? 3'b101 : 3'b011;
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: table vectors, corner sequences and random stimulus against a frame-position model
module tb_hex_display_scanner;
  localparam int TPD = 8;
  localparam int BT = 2;
  localparam int FR = 3 * TPD;
  logic clk = 0, reset = 1, enable = 1;
  logic [4:0] hex2 = 0, hex1 = 0, hex0 = 0;
  logic [7:0] seg;
  logic [2:0] an;
  logic frame_tick;
  hex_display_scanner #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  logic [7:0] segtab [32] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
                              8'hBF, 8'hF7, 8'hFF, 8'hFE, 8'hA3, 8'h9C, 8'hCF, 8'hC9,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int total = 0, bad = 0;
  int p = 0, last_p = -1, since = -1;
  logic [4:0] m[3] = '{5'h12, 5'h12, 5'h12};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] mseg(input int s);
    logic [4:0] c;
    c = m[s];
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 2 && m[2] == 0) c = 5'h12;
    if (s == 1 && m[2] == 0 && m[1] == 0) c = 5'h12;
`endif
    return segtab[c];
  endfunction
  // Model: the DUT state is just a position 0..FR-1 within the frame; outputs follow one clock later
  task automatic cyc();
    logic [7:0] es;
    logic [2:0] ea;
    logic ef, rs;
    int s, t;
    rs = reset;
    if (reset) begin
      es = 8'hFF; ea = 3'b111; ef = 0; p = 0; last_p = -1;
      m = '{5'h12, 5'h12, 5'h12};
    end else begin
      s = p / TPD; t = p % TPD;
      if (p == 0) begin m[0] = hex0; m[1] = hex1; m[2] = hex2; end
      es = mseg(s);
      ea = (t < BT || !enable) ? 3'b111 : 3'b111 ^ (3'b001 << s);
      ef = p == 0;
      last_p = p;
      p = (p + 1) % FR;
    end
    @(posedge clk);
    #1;
    chk("seg", seg, es);
    chk("an", an, ea);
    chk("frame_tick", frame_tick, ef);
    if (rs) since = -1;
    else begin
      if (since >= 0) since++;
      if (frame_tick) begin
        if (since > 0) chk("ft_period", since, FR);
        since = 0;
      end
    end
  endtask
  task automatic run_to(input int q);
    int n;
    n = 0;
    do begin cyc(); n++; end while (last_p != q && n < 2 * FR);
    if (last_p != q) chk("run_to_timeout", last_p, q);
  endtask
  typedef struct { logic [4:0] h2, h1, h0; logic en; logic [7:0] s2, s1, s0; } vec_t;
  vec_t vt[7];
  initial begin
    vt[0] = '{5'h01, 5'h17, 5'h16, 1'b1, 8'hF9, 8'hC9, 8'hCF};
    vt[1] = '{5'h12, 5'h12, 5'h12, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    vt[2] = '{5'h0A, 5'h0B, 5'h0C, 1'b1, 8'h88, 8'h83, 8'hC6};
    vt[3] = '{5'h10, 5'h11, 5'h13, 1'b0, 8'hBF, 8'hF7, 8'hFE};
    vt[4] = '{5'h14, 5'h15, 5'h1F, 1'b1, 8'hA3, 8'h9C, 8'hFF};
`ifdef LEADING_ZERO_BLANK_EN
    vt[5] = '{5'h00, 5'h00, 5'h00, 1'b1, 8'hFF, 8'hFF, 8'hC0};
    vt[6] = '{5'h00, 5'h05, 5'h00, 1'b1, 8'hFF, 8'h92, 8'hC0};
`else
    vt[5] = '{5'h00, 5'h00, 5'h00, 1'b1, 8'hC0, 8'hC0, 8'hC0};
    vt[6] = '{5'h00, 5'h05, 5'h00, 1'b1, 8'hC0, 8'h92, 8'hC0};
`endif
    repeat (3) cyc();
    reset = 0;
    cyc();
    chk("first_ft", frame_tick, 1);
    foreach (vt[i]) begin
      run_to(FR - 1);
      {hex2, hex1, hex0, enable} = {vt[i].h2, vt[i].h1, vt[i].h0, vt[i].en};
      repeat (FR) begin
        cyc();
        if (last_p == 4) begin chk("vec_s0", seg, vt[i].s0); chk("vec_an0", an, vt[i].en ? 3'b110 : 3'b111); end
        if (last_p == 4 + TPD) chk("vec_s1", seg, vt[i].s1);
        if (last_p == 4 + 2 * TPD) chk("vec_s2", seg, vt[i].s2);
      end
    end
    enable = 1;
    run_to(FR - 1);
    {hex2, hex1, hex0} = {5'h01, 5'h17, 5'h16};
    run_to(TPD + 4);
    chk("mid_s1_old", seg, 8'hC9);
    run_to(2 * TPD + 1);
    hex1 = 5'h12;
    run_to(2 * TPD + 4);
    chk("mid_s2_same", seg, 8'hF9);
    run_to(TPD + 4);
    chk("mid_s1_new", seg, 8'hFF);
    run_to(12);
    reset = 1;
    cyc();
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 3'b111);
    chk("rst_ft", frame_tick, 0);
    reset = 0;
    cyc();
    chk("rel_ft", frame_tick, 1);
    run_to(FR - 1);
    enable = 0;
    repeat (FR) begin cyc(); chk("dis_an", an, 3'b111); end
    enable = 1;
    run_to(4);
    chk("reen_an", an, 3'b110);
    for (int c = 0; c < 32; c++) begin
      run_to(FR - 1);
      hex0 = 5'(c);
      run_to(4);
      chk("code_sweep", seg, segtab[c]);
    end
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) hex0 = 5'($urandom);
      if ($urandom_range(5) == 0) hex1 = 5'($urandom_range(3) == 0 ? 0 : $urandom);
      if ($urandom_range(5) == 0) hex2 = 5'($urandom_range(2) == 0 ? 0 : $urandom);
      if ($urandom_range(19) == 0) enable = ~enable;
      reset = $urandom_range(199) == 0;
      cyc();
    end
    reset = 0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
